// File: rtl/block_table.sv
// block_table: fixed pool of live blocks with valid/ready spawn, per-tick z advance,
// slice and expiry retirement, and registered per-slot outputs.
`default_nettype none

module block_table #(
  parameter int NUM_SLOTS = 12,
  parameter int X_WIDTH   = 12,
  parameter int Y_WIDTH   = 12,
  parameter int Z_WIDTH   = 14,
  parameter int Z_SPAWN   = 8000,
  parameter int Z_STEP    = 64,
  localparam int SW = $clog2(NUM_SLOTS),
  localparam int CW = $clog2(NUM_SLOTS + 1)
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic                                clear_in,
  input  logic                                tick_in,
  input  logic                                spawn_valid_in,
  output logic                                spawn_ready_out,
  input  logic [X_WIDTH-1:0]                  spawn_x_in,
  input  logic [Y_WIDTH-1:0]                  spawn_y_in,
  input  logic                                spawn_color_in,
  input  logic [2:0]                          spawn_direction_in,
  input  logic                                slice_valid_in,
  input  logic [SW-1:0]                       slice_slot_in,
  output logic [NUM_SLOTS-1:0][X_WIDTH-1:0]   block_x_out,
  output logic [NUM_SLOTS-1:0][Y_WIDTH-1:0]   block_y_out,
  output logic [NUM_SLOTS-1:0][Z_WIDTH-1:0]   block_z_out,
  output logic [NUM_SLOTS-1:0]                block_color_out,
  output logic [NUM_SLOTS-1:0][2:0]           block_direction_out,
  output logic [NUM_SLOTS-1:0]                block_visible_out,
  output logic                                sliced_out,
  output logic                                missed_out,
  output logic [CW-1:0]                       miss_count_out,
  output logic [CW-1:0]                       active_count_out
);

  localparam logic [Z_WIDTH-1:0] Z_SPAWN_V = Z_WIDTH'(Z_SPAWN);
  localparam logic [Z_WIDTH-1:0] Z_STEP_V  = Z_WIDTH'(Z_STEP);

  logic [NUM_SLOTS-1:0]              spawn_onehot;
  logic                              spawn_fire;
  logic [NUM_SLOTS-1:0]              visible_nxt;
  logic [NUM_SLOTS-1:0][Z_WIDTH-1:0] z_nxt;
  logic [NUM_SLOTS-1:0]              load;
  logic                              slice_hit;
  logic [CW-1:0]                     miss_cnt;
  logic [CW-1:0]                     active_nxt;

  assign spawn_ready_out = |(~block_visible_out);

  // Isolates the lowest clear bit of the visible vector: lowest-index free slot.
  assign spawn_onehot = ~block_visible_out & (block_visible_out + NUM_SLOTS'(1));
  assign spawn_fire   = spawn_valid_in & spawn_ready_out & ~clear_in;

  always_comb begin
    visible_nxt = block_visible_out;
    z_nxt       = block_z_out;
    load        = '0;
    slice_hit   = 1'b0;
    miss_cnt    = '0;
    if (clear_in) begin
      visible_nxt = '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (block_visible_out[i]) begin
          // Slice takes priority over expiry on the same slot.
          if (slice_valid_in && (slice_slot_in == SW'(i))) begin
            visible_nxt[i] = 1'b0;
            slice_hit      = 1'b1;
          end else if (tick_in) begin
            if (block_z_out[i] <= Z_STEP_V) begin
              visible_nxt[i] = 1'b0;
              miss_cnt       = miss_cnt + CW'(1);
            end else begin
              z_nxt[i] = block_z_out[i] - Z_STEP_V;
            end
          end
        end else if (spawn_fire && spawn_onehot[i]) begin
          visible_nxt[i] = 1'b1;
          z_nxt[i]       = Z_SPAWN_V;
          load[i]        = 1'b1;
        end
      end
    end
  end

  always_comb begin
    active_nxt = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      active_nxt = active_nxt + CW'(visible_nxt[i]);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      block_x_out         <= '0;
      block_y_out         <= '0;
      block_z_out         <= '0;
      block_color_out     <= '0;
      block_direction_out <= '0;
      block_visible_out   <= '0;
      sliced_out          <= 1'b0;
      missed_out          <= 1'b0;
      miss_count_out      <= '0;
      active_count_out    <= '0;
    end else begin
      block_visible_out <= visible_nxt;
      block_z_out       <= z_nxt;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (load[i]) begin
          block_x_out[i]         <= spawn_x_in;
          block_y_out[i]         <= spawn_y_in;
          block_color_out[i]     <= spawn_color_in;
          block_direction_out[i] <= spawn_direction_in;
        end
      end
      sliced_out       <= slice_hit;
      missed_out       <= (miss_cnt != '0);
      miss_count_out   <= miss_cnt;
      active_count_out <= active_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_block_table.sv
// tb_block_table: directed scenarios plus randomized traffic against a slot-pool model.
`default_nettype none

module tb_block_table;

  localparam int N  = 12;
  localparam int ZS = 8000;
  localparam int ZD = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clear = 1'b0;
  logic tick = 1'b0;
  logic sv = 1'b0;
  logic ready;
  logic [11:0] sx = '0;
  logic [11:0] sy = '0;
  logic scol = 1'b0;
  logic [2:0] sdir = '0;
  logic slv = 1'b0;
  logic [3:0] sls = '0;
  logic [N-1:0][11:0] bx;
  logic [N-1:0][11:0] by;
  logic [N-1:0][13:0] bz;
  logic [N-1:0] bcol;
  logic [N-1:0][2:0] bdir;
  logic [N-1:0] bvis;
  logic sliced, missed;
  logic [3:0] mcount, active;

  block_table dut (
    .clk_in(clk), .rst_in(rst), .clear_in(clear), .tick_in(tick),
    .spawn_valid_in(sv), .spawn_ready_out(ready),
    .spawn_x_in(sx), .spawn_y_in(sy), .spawn_color_in(scol),
    .spawn_direction_in(sdir), .slice_valid_in(slv), .slice_slot_in(sls),
    .block_x_out(bx), .block_y_out(by), .block_z_out(bz),
    .block_color_out(bcol), .block_direction_out(bdir),
    .block_visible_out(bvis), .sliced_out(sliced), .missed_out(missed),
    .miss_count_out(mcount), .active_count_out(active)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference pool: one record per slot, plus the expected pulse outputs.
  int m_vis [N];
  int m_x [N];
  int m_y [N];
  int m_z [N];
  int m_col [N];
  int m_dir [N];
  int e_sliced, e_missed, e_mcount;

  function automatic int model_active();
    int c = 0;
    for (int i = 0; i < N; i++) c += m_vis[i];
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_vis[i] = 0; m_x[i] = 0; m_y[i] = 0; m_z[i] = 0; m_col[i] = 0; m_dir[i] = 0;
    end
    e_sliced = 0; e_missed = 0; e_mcount = 0;
  endtask

  task automatic model_edge();
    int first_free = -1;
    for (int i = N - 1; i >= 0; i--) if (m_vis[i] == 0) first_free = i;
    e_sliced = 0; e_mcount = 0;
    if (clear) begin
      for (int i = 0; i < N; i++) m_vis[i] = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (m_vis[i] == 1) begin
          if (slv && int'(sls) == i) begin
            m_vis[i] = 0; e_sliced = 1;
          end else if (tick) begin
            if (m_z[i] <= ZD) begin
              m_vis[i] = 0; e_mcount++;
            end else m_z[i] = m_z[i] - ZD;
          end
        end
      end
      if (sv && first_free >= 0) begin
        m_vis[first_free] = 1; m_z[first_free] = ZS;
        m_x[first_free] = sx; m_y[first_free] = sy;
        m_col[first_free] = scol; m_dir[first_free] = sdir;
      end
    end
    e_missed = (e_mcount > 0) ? 1 : 0;
  endtask

  // One clock: advance the model with the current inputs, clock the DUT, drop pulses.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    tick = 0; sv = 0; slv = 0; clear = 0;
  endtask

  task automatic spawn(input int x);
    sv = 1; sx = 12'(x); sy = 12'($urandom); scol = 1'($urandom); sdir = 3'($urandom);
    step();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      tick = 1;
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1;
    model_reset();
    #3;
    checks++; if (bvis !== '0) $display("FAIL reset_visible got %h want 0", bvis); else passed++;
    checks++; if (active !== 4'd0) $display("FAIL reset_active got %0d want 0", active); else passed++;
    checks++; if (ready !== 1'b1) $display("FAIL reset_ready got %b want 1", ready); else passed++;
    checks++; if ({sliced, missed, mcount} !== 6'b0) $display("FAIL reset_pulses got %b%b%0d want 0", sliced, missed, mcount); else passed++;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_back_to_back();
    spawn(10); spawn(20); spawn(30);
    checks++; if (bvis !== 12'h007) $display("FAIL b2b_visible got %h want 007", bvis); else passed++;
    checks++; if (active !== 4'd3) $display("FAIL b2b_active got %0d want 3", active); else passed++;
    checks++; if (bx[0] !== 12'd10 || bx[2] !== 12'd30) $display("FAIL b2b_x got %0d/%0d want 10/30", bx[0], bx[2]); else passed++;
    checks++; if (bz[1] !== 14'd8000) $display("FAIL b2b_z got %0d want 8000", bz[1]); else passed++;
  endtask

  task automatic test_fill();
    for (int k = 3; k < N; k++) spawn(100 + k);
    checks++; if (ready !== 1'b0) $display("FAIL full_ready got %b want 0", ready); else passed++;
    spawn(999);
    checks++; if (active !== 4'd12) $display("FAIL full_reject got %0d want 12", active); else passed++;
    slv = 1; sls = 4'd5;
    step();
    checks++; if (sliced !== 1'b1 || ready !== 1'b1) $display("FAIL slice5 got sliced=%b ready=%b want 1/1", sliced, ready); else passed++;
    spawn(555);
    checks++; if (bx[5] !== 12'd555 || bvis !== 12'hfff) $display("FAIL refill5 got x=%0d vis=%h want 555/fff", bx[5], bvis); else passed++;
  endtask

  task automatic test_expire();
    clear = 1; step();
    spawn(1);
    ticks(124);
    checks++; if (bz[0] !== 14'd64 || bvis[0] !== 1'b1) $display("FAIL pre_expire got z=%0d vis=%b want 64/1", bz[0], bvis[0]); else passed++;
    ticks(1);
    checks++; if (bvis[0] !== 1'b0 || missed !== 1'b1 || mcount !== 4'd1) $display("FAIL expire got vis=%b missed=%b cnt=%0d want 0/1/1", bvis[0], missed, mcount); else passed++;
    step();
    checks++; if (missed !== 1'b0 || mcount !== 4'd0) $display("FAIL expire_one_cycle got missed=%b cnt=%0d want 0/0", missed, mcount); else passed++;
  endtask

  task automatic test_dual_expire();
    clear = 1; step();
    spawn(2); spawn(3);
    ticks(125);
    checks++; if (missed !== 1'b1 || mcount !== 4'd2 || active !== 4'd0) $display("FAIL dual_expire got missed=%b cnt=%0d act=%0d want 1/2/0", missed, mcount, active); else passed++;
  endtask

  task automatic test_slice_vs_tick();
    clear = 1; step();
    spawn(4);
    ticks(124);
    tick = 1; slv = 1; sls = 4'd0;
    step();
    checks++; if (sliced !== 1'b1 || missed !== 1'b0) $display("FAIL slice_wins got sliced=%b missed=%b want 1/0", sliced, missed); else passed++;
    slv = 1; sls = 4'd7;
    step();
    checks++; if (sliced !== 1'b0) $display("FAIL slice_empty got %b want 0", sliced); else passed++;
    slv = 1; sls = 4'd14;
    step();
    checks++; if (sliced !== 1'b0) $display("FAIL slice_oob got %b want 0", sliced); else passed++;
  endtask

  task automatic test_spawn_tick();
    clear = 1; step();
    spawn(5); spawn(6);
    ticks(1);
    sv = 1; sx = 12'd7; tick = 1;
    step();
    checks++; if (bz[2] !== 14'd8000 || bvis[2] !== 1'b1) $display("FAIL spawn_tick_new got z=%0d want 8000", bz[2]); else passed++;
    checks++; if (bz[0] !== 14'd7872 || bz[1] !== 14'd7872) $display("FAIL spawn_tick_old got %0d/%0d want 7872", bz[0], bz[1]); else passed++;
  endtask

  task automatic test_clear();
    logic [13:0] z0;
    spawn(8);
    z0 = bz[0];
    clear = 1; tick = 1; slv = 1; sls = 4'd1; sv = 1;
    step();
    checks++; if (bvis !== '0 || active !== 4'd0) $display("FAIL clear got vis=%h act=%0d want 0/0", bvis, active); else passed++;
    checks++; if (sliced !== 1'b0 || missed !== 1'b0) $display("FAIL clear_pulses got %b/%b want 0/0", sliced, missed); else passed++;
    checks++; if (bz[0] !== z0) $display("FAIL clear_hold got z=%0d want %0d", bz[0], z0); else passed++;
  endtask

  task automatic test_async_reset();
    spawn(9); spawn(11);
    tick = 1;
    #2;
    rst = 1;
    model_reset();
    #1;
    checks++; if (bvis !== '0 || active !== 4'd0 || bz[0] !== 14'd0 || bx[1] !== 12'd0) $display("FAIL async_reset got vis=%h act=%0d z=%0d x=%0d want 0", bvis, active, bz[0], bx[1]); else passed++;
    @(posedge clk); #1;
    rst = 0; tick = 0;
    spawn(77);
    checks++; if (bvis !== 12'h001 || bx[0] !== 12'd77) $display("FAIL post_reset_spawn got vis=%h x=%0d want 001/77", bvis, bx[0]); else passed++;
  endtask

  task automatic test_random();
    int errs;
    for (int c = 0; c < 1500; c++) begin
      tick  = ($urandom_range(0, 99) < 60);
      sv    = ($urandom_range(0, 99) < 25);
      slv   = ($urandom_range(0, 99) < 15);
      clear = ($urandom_range(0, 999) < 4);
      sls   = 4'($urandom);
      sx    = 12'($urandom); sy = 12'($urandom);
      scol  = 1'($urandom); sdir = 3'($urandom);
      checks++;
      if (int'(ready) !== ((model_active() < N) ? 1 : 0)) $display("FAIL rnd_ready cyc %0d got %b", c, ready); else passed++;
      step();
      errs = 0;
      for (int i = 0; i < N; i++) begin
        if (int'(bvis[i]) != m_vis[i] || int'(bz[i]) != m_z[i] || int'(bx[i]) != m_x[i] ||
            int'(by[i]) != m_y[i] || int'(bcol[i]) != m_col[i] || int'(bdir[i]) != m_dir[i]) errs++;
      end
      checks++;
      if (errs != 0) $display("FAIL rnd_slots cyc %0d bad slots %0d want 0", c, errs); else passed++;
      checks++;
      if (int'(sliced) != e_sliced || int'(missed) != e_missed || int'(mcount) != e_mcount || int'(active) != model_active())
        $display("FAIL rnd_status cyc %0d got s=%b m=%b c=%0d a=%0d want %0d/%0d/%0d/%0d",
                 c, sliced, missed, mcount, active, e_sliced, e_missed, e_mcount, model_active());
      else passed++;
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_back_to_back();
    test_fill();
    test_expire();
    test_dual_expire();
    test_slice_vs_tick();
    test_spawn_tick();
    test_clear();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/block_table.md
# block_table

Parametrised, stateful successor to the fixed 12-block loader/positions pair in the game logic and renderer path. Holds up to NUM_SLOTS live blocks and accepts new blocks through a valid/ready spawn port. On each game tick it advances every live block toward the player, and it retires blocks that are sliced or missed. Its packed per-slot outputs feed the block selector, state processor and renderer directly, and its slice/miss pulses feed game state.

## Interface
Parameters:
- NUM_SLOTS, 12, number of block slots (2..32)
- X_WIDTH, 12, block x width
- Y_WIDTH, 12, block y width
- Z_WIDTH, 14, block z width
- Z_SPAWN, 8000, z loaded on spawn (must be < 2^Z_WIDTH)
- Z_STEP, 64, z decrement per tick (must be ≥ 1 and < Z_SPAWN)
- SW = $clog2(NUM_SLOTS), CW = $clog2(NUM_SLOTS+1) (derived, not overridable)

Ports:
- clk_in  in  1  system clock; all state changes on its rising edge
- rst_in  in  1  reset; asynchronous, active-high
- clear_in  in  1  synchronous empty-all (game restart)
- tick_in  in  1  single-cycle pulse; advance all live blocks
- spawn_valid_in  in  1  spawn request
- spawn_ready_out  out  1  at least one free slot
- spawn_x_in  in  X_WIDTH  spawn x
- spawn_y_in  in  Y_WIDTH  spawn y
- spawn_color_in  in  1  spawn color
- spawn_direction_in  in  3  spawn cut direction
- slice_valid_in  in  1  slice request
- slice_slot_in  in  SW  slot index to slice
- block_x_out  out  [NUM_SLOTS][X_WIDTH]  per-slot x
- block_y_out  out  [NUM_SLOTS][Y_WIDTH]  per-slot y
- block_z_out  out  [NUM_SLOTS][Z_WIDTH]  per-slot z
- block_color_out  out  [NUM_SLOTS]  per-slot color
- block_direction_out  out  [NUM_SLOTS][3]  per-slot direction
- block_visible_out  out  [NUM_SLOTS]  slot occupied
- sliced_out  out  1  one-cycle pulse; a live block was sliced
- missed_out  out  1  one-cycle pulse; one or more blocks expired
- miss_count_out  out  CW  number of blocks expired by the tick that raised missed_out
- active_count_out  out  CW  count of visible slots

## Operation
- Reset (async assert): all visible=0, x/y/z/color/direction=0, sliced_out=0, missed_out=0, miss_count_out=0, active_count_out=0. spawn_ready_out=1 as soon as reset is asserted.
- spawn_ready_out is combinational: the OR of ~visible across all slots, taken from registered state. A slot freed this cycle is not reusable until the next cycle.
- Spawn accepted when spawn_valid_in & spawn_ready_out. The lowest-index free slot loads the inputs, with z=Z_SPAWN and visible=1.
- Tick: every slot that was visible before this edge and is not being sliced behaves as follows:
  - If z ≤ Z_STEP: visible←0, z held, counted as a miss.
  - Otherwise: z←z−Z_STEP.
  - Unsigned arithmetic, no wrap possible.
- Slice: if slot slice_slot_in is visible, visible←0 and sliced_out pulses next cycle. If the slot is empty or slice_slot_in ≥ NUM_SLOTS, the request is ignored and no pulse is produced.
- missed_out=1 and miss_count_out=N for one cycle after a tick that expires N≥1 blocks. Otherwise both are 0.
- active_count_out is registered and equals popcount(visible) after each edge.
- Simultaneous events in one cycle:
  - Slice and tick expiring the same slot: the slice wins; sliced pulse, no miss for that slot.
  - Spawn and tick: the newly spawned block holds exactly Z_SPAWN (not decremented).
  - Spawn and slice/expiry elsewhere: all are applied.
- clear_in: all visible←0, no sliced/missed pulses, spawn/slice/tick ignored that cycle. x/y/z/color/direction are held.
- Free slots keep their last x/y/z/color/direction. Consumers must qualify on block_visible_out.

## Timing
- All outputs except spawn_ready_out are registered, with latency 1 cycle from the triggering input edge.
- spawn_ready_out has 0-cycle combinational dependence on state only. It does not depend on spawn_valid_in (no loop).
- Throughput: one spawn, one slice and one tick per cycle.
- Reset mid-operation clears immediately and asynchronously. The first accepted spawn after deassertion lands in slot 0.

## Test plan
- Reset, then 3 spawns back-to-back with x=10,20,30 → slots 0,1,2 visible, z=8000, active_count_out=3, slot 0 x=10.
- Fill all 12 slots → spawn_ready_out=0, and a 13th valid is not accepted. Slice slot 5 → next cycle ready=1. The next spawn lands in slot 5.
- One spawned block, 125 ticks → z=8000−125·64=0? No: after 124 ticks z=64. Tick 125 expires it: visible=0, missed_out=1, miss_count_out=1 for exactly one cycle.
- Two blocks spawned in the same cycle window expire on the same tick → miss_count_out=2, single missed_out pulse.
- Slice slot 0 in the same cycle as the expiring tick → sliced_out=1, missed_out=0. Slice an empty slot 7 → no pulse.
- Spawn with tick asserted in the same cycle → new block z=8000 and existing blocks decremented by 64. Assert clear_in with 4 live blocks → all visible=0, active_count_out=0, no pulses. Assert rst_in mid-tick → outputs zero before the next edge.
